sisc_mem_arbiter: RTL and testbench
===================================

# sisc_mem_arbiter

Arbitrates the single-ported SISC memory between three requesters: data access (LOD/STR from the datapath), instruction fetch (IR load) and the debug/loader port. Each access is sequenced through a fixed issue/wait/respond cycle, and the result is returned with a one-cycle done pulse. The block sits between the `ctrl` FSM, the PC/IR fetch path and the memory macro, and it is the only block that drives the memory pins.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 32, data width
- `MEM_LAT`, 1, memory read latency in cycles, legal range 1..7
- `STARVE_MAX`, 8, number of lost arbitrations after which the debug port is forced to win, legal range 1..15

Ports (suffix key: `d` = data, `f` = fetch, `g` = debug; `_x` stands for each of the three):
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `hold`  in  1  CPU halted; only the debug port is eligible while high
- `req_x`  in  1  access request (level)
- `we_x`  in  1  1 = write, 0 = read
- `addr_x`  in  AW  access address
- `wdata_x`  in  DW  write data
- `gnt_x`  out  1  owner flag, one-hot
- `done_x`  out  1  one-cycle completion pulse
- `rdata`  out  DW  read data returned to the owner
- `busy`  out  1  high when the FSM is not in IDLE
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data

## Operation
- Reset values: FSM in IDLE; `gnt_x`, `done_x`, `busy`, `mem_en` and `mem_we` all 0; `mem_addr`, `mem_wdata` and `rdata` all 0; starvation counter 0; wait counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE → ISSUE when at least one eligible request is present; otherwise stay in IDLE.
  - ISSUE → WAIT unconditionally.
  - WAIT stays for exactly MEM_LAT cycles, then → RESP.
  - RESP → IDLE unconditionally.
- Arbitration happens only in IDLE. Priority order is d > f > g, with one override: if `req_g` is high and the starvation counter equals STARVE_MAX, g wins.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on each arbitration in which `req_g` is high and g loses.
  - Clears when g wins.
  - Otherwise holds its value.
- `hold` = 1: `req_d` and `req_f` are ignored and only g is arbitrated. An access already in flight always completes.
- Winner registration: on the IDLE→ISSUE edge the winner's `we`, `addr` and `wdata` are registered into `mem_we`, `mem_addr` and `mem_wdata`, and `gnt_x` is set for the winner. `gnt_x` stays high through ISSUE, WAIT and RESP and clears on the edge into IDLE.
- `mem_en` is high only in ISSUE. `mem_we` is qualified by `mem_en` and is 0 outside ISSUE. `mem_addr` and `mem_wdata` hold their value until the next issue.
- Reads: `mem_rdata` is sampled into `rdata` on the edge that ends the last WAIT cycle. Writes leave `rdata` unchanged.
- `done_x` is high for the single RESP cycle of the owner. `rdata` is valid in that cycle and holds until the next read completes.
- Requester rules:
  - `req`, `we`, `addr` and `wdata` are held stable from assertion until `done`.
  - A `req` still high in the IDLE cycle after RESP counts as a new request.
  - Requests that drop before being granted are simply not served; no error is raised.
- `busy` = (state != IDLE).

## Timing
- A request sampled in IDLE cycle t produces: ISSUE at t+1, WAIT from t+2 to t+1+MEM_LAT, RESP (`done` high) at t+2+MEM_LAT.
- Maximum throughput is one access per MEM_LAT+3 cycles, one of which is the IDLE arbitration cycle.
- Read data path: `mem_rdata` must be valid MEM_LAT cycles after the `mem_en` cycle. It is captured at the end of cycle t+1+MEM_LAT.
- Simultaneous requests: all are decided in the same IDLE cycle by priority. Losers keep `req` high and are re-arbitrated in the next IDLE cycle.
- `hold` is sampled only in IDLE. Changing it mid-access has no effect on that access.
- Reset asserted mid-access: the FSM returns to IDLE and every output goes to its reset value immediately (asynchronously). No `done` is generated for the aborted access; the requester re-requests after reset.

## Test plan
- Single read on d, MEM_LAT=1, addr=0x0010, memory model returns 0xDEADBEEF: `mem_en` high 1 cycle after req is sampled; `done_d` 3 cycles after sampling; `rdata`=0xDEADBEEF.
- Single write on f, addr=0x0003, wdata=0x12345678: `mem_we`=1 only in ISSUE; `done_f` at t+3; `rdata` unchanged from its previous value.
- `req_d`, `req_f` and `req_g` all asserted in the same cycle: served in the order d, f, g. Each `gnt` is one-hot and each `done` is separated by 4 cycles (MEM_LAT=1).
- Starvation with STARVE_MAX=2: d and f request back-to-back continuously while g requests. g wins on the 3rd arbitration, after two losses; the counter returns to 0 afterwards.
- `hold`=1 with d, f and g all requesting: only g is granted. Deassert `hold`: d is granted at the next IDLE.
- Assert `rst` during WAIT of a d read: `gnt_d`, `mem_en` and `busy` are 0 in the same cycle; no `done_d` appears; after `rst` is released, a new request completes normally. Repeat the basic read with MEM_LAT=4: `done` at t+6.

Source files
------------

// File: rtl/sisc_mem_arbiter.sv
// rtl/sisc_mem_arbiter.sv - single-port SISC memory arbiter (data, fetch, debug)
module sisc_mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          req_d,
    input  logic          we_d,
    input  logic [AW-1:0] addr_d,
    input  logic [DW-1:0] wdata_d,
    input  logic          req_f,
    input  logic          we_f,
    input  logic [AW-1:0] addr_f,
    input  logic [DW-1:0] wdata_f,
    input  logic          req_g,
    input  logic          we_g,
    input  logic [AW-1:0] addr_g,
    input  logic [DW-1:0] wdata_g,
    output logic          gnt_d,
    output logic          gnt_f,
    output logic          gnt_g,
    output logic          done_d,
    output logic          done_f,
    output logic          done_g,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_LAST   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic [2:0] wait_cnt;
    logic [3:0] starve_cnt;
    logic       acc_we;

    logic elig_d, elig_f, elig_g, any_elig, force_g;
    logic win_d, win_f, win_g;

    // hold masks the CPU-side requesters; debug stays eligible
    always_comb begin
        elig_d   = req_d & ~hold;
        elig_f   = req_f & ~hold;
        elig_g   = req_g;
        any_elig = elig_d | elig_f | elig_g;
        force_g  = req_g && (starve_cnt == STARVE_LIM);
        win_d    = !force_g && elig_d;
        win_f    = !force_g && !elig_d && elig_f;
        win_g    = force_g || (elig_g && !elig_d && !elig_f);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            acc_we     <= 1'b0;
            gnt_d      <= 1'b0;
            gnt_f      <= 1'b0;
            gnt_g      <= 1'b0;
            done_d     <= 1'b0;
            done_f     <= 1'b0;
            done_g     <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            done_d <= 1'b0;
            done_f <= 1'b0;
            done_g <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        state  <= ISSUE;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        gnt_d  <= win_d;
                        gnt_f  <= win_f;
                        gnt_g  <= win_g;
                        if (win_d) begin
                            mem_we    <= we_d;
                            acc_we    <= we_d;
                            mem_addr  <= addr_d;
                            mem_wdata <= wdata_d;
                        end else if (win_f) begin
                            mem_we    <= we_f;
                            acc_we    <= we_f;
                            mem_addr  <= addr_f;
                            mem_wdata <= wdata_f;
                        end else begin
                            mem_we    <= we_g;
                            acc_we    <= we_g;
                            mem_addr  <= addr_g;
                            mem_wdata <= wdata_g;
                        end
                        if (win_g)
                            starve_cnt <= '0;
                        else if (req_g && starve_cnt != STARVE_LIM)
                            starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (wait_cnt == LAT_LAST) begin
                        state  <= RESP;
                        done_d <= gnt_d;
                        done_f <= gnt_f;
                        done_g <= gnt_g;
                        if (!acc_we)
                            rdata <= mem_rdata;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    gnt_d    <= 1'b0;
                    gnt_f    <= 1'b0;
                    gnt_g    <= 1'b0;
                    wait_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sisc_mem_arbiter.sv
// tb/tb_sisc_mem_arbiter.sv - directed self-checking bench for sisc_mem_arbiter
module tb_sisc_mem_arbiter;

    logic        clk, rst, hold;
    logic        req_d, we_d, req_f, we_f, req_g, we_g;
    logic [15:0] addr_d, addr_f, addr_g;
    logic [31:0] wdata_d, wdata_f, wdata_g;

    logic        gnt_d, gnt_f, gnt_g, done_d, done_f, done_g, busy, mem_en, mem_we;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    logic        d2_gnt_d, d2_gnt_f, d2_gnt_g, d2_done_d, d2_done_f, d2_done_g;
    logic        d2_busy, d2_mem_en, d2_mem_we;
    logic [31:0] d2_rdata, d2_mem_wdata, d2_mem_rdata;
    logic [15:0] d2_mem_addr;

    logic [15:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] mem_model(input logic [15:0] a);
        return (a == 16'h0010) ? 32'hDEADBEEF : {16'hA5A5, a};
    endfunction

    assign mem_rdata    = mem_model(mem_addr);
    assign d2_mem_rdata = mem_model(d2_mem_addr);

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    sisc_mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(1), .STARVE_MAX(2)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_d(req_d), .we_d(we_d), .addr_d(addr_d), .wdata_d(wdata_d),
        .req_f(req_f), .we_f(we_f), .addr_f(addr_f), .wdata_f(wdata_f),
        .req_g(req_g), .we_g(we_g), .addr_g(addr_g), .wdata_g(wdata_g),
        .gnt_d(gnt_d), .gnt_f(gnt_f), .gnt_g(gnt_g),
        .done_d(done_d), .done_f(done_f), .done_g(done_g),
        .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    sisc_mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(4), .STARVE_MAX(8)) dut_lat4 (
        .clk(clk), .rst(rst), .hold(hold),
        .req_d(req_d), .we_d(we_d), .addr_d(addr_d), .wdata_d(wdata_d),
        .req_f(req_f), .we_f(we_f), .addr_f(addr_f), .wdata_f(wdata_f),
        .req_g(req_g), .we_g(we_g), .addr_g(addr_g), .wdata_g(wdata_g),
        .gnt_d(d2_gnt_d), .gnt_f(d2_gnt_f), .gnt_g(d2_gnt_g),
        .done_d(d2_done_d), .done_f(d2_done_f), .done_g(d2_done_g),
        .rdata(d2_rdata), .busy(d2_busy), .mem_en(d2_mem_en), .mem_we(d2_mem_we),
        .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata), .mem_rdata(d2_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps ncyc cycles; records done timing relative to the current cycle
    task automatic run_reqs(input int ncyc, input bit keep,
                            output int first_d, output int first_f, output int first_g,
                            output int last_g, output int cnt_d, output int cnt_f,
                            output int bad);
        first_d = -1; first_f = -1; first_g = -1; last_g = -1;
        cnt_d = 0; cnt_f = 0; bad = 0;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if ($countones({gnt_d, gnt_f, gnt_g}) > 1) bad++;
            if (done_d) begin
                cnt_d++;
                if (first_d < 0) first_d = c;
                if (!keep) req_d = 1'b0;
            end
            if (done_f) begin
                cnt_f++;
                if (first_f < 0) first_f = c;
                if (!keep) req_f = 1'b0;
            end
            if (done_g) begin
                if (first_g < 0) first_g = c;
                last_g = c;
                hold   = 1'b0;
                if (!keep) req_g = 1'b0;
            end
        end
    endtask

    int fd, ff, fg, lg, cd, cf, bad;
    int n_done, d1_first, d2_first, d2_en;
    logic [31:0] d2_rd_seen;

    initial begin
        rst = 1'b1; hold = 1'b0;
        req_d = 0; we_d = 0; addr_d = '0; wdata_d = '0;
        req_f = 0; we_f = 0; addr_f = '0; wdata_f = '0;
        req_g = 0; we_g = 0; addr_g = '0; wdata_g = '0;
        tick();
        tick();
        check_val("rst_flags", {gnt_d, gnt_f, gnt_g, done_d, done_f, done_g, busy, mem_en, mem_we}, 0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_wdata", mem_wdata, 0);
        check_val("rst_rdata", rdata, 0);
        rst = 1'b0;
        tick();

        // single read on d
        addr_d = 16'h0010; we_d = 1'b0; req_d = 1'b1;
        check_val("rd_en_t0", mem_en, 0);
        tick();
        check_val("rd_en_t1", mem_en, 1);
        check_val("rd_gnt_t1", {gnt_d, gnt_f, gnt_g}, 3'b100);
        check_val("rd_we_t1", mem_we, 0);
        check_val("rd_addr_t1", mem_addr, 16'h0010);
        check_val("rd_busy_t1", busy, 1);
        tick();
        check_val("rd_en_t2", mem_en, 0);
        check_val("rd_done_t2", done_d, 0);
        tick();
        check_val("rd_done_t3", done_d, 1);
        check_val("rd_rdata_t3", rdata, 32'hDEADBEEF);
        req_d = 1'b0;
        tick();
        check_val("rd_idle_t4", {done_d, gnt_d, busy}, 0);
        check_val("rd_rdata_hold", rdata, 32'hDEADBEEF);

        // single write on f
        addr_f = 16'h0003; we_f = 1'b1; wdata_f = 32'h12345678; req_f = 1'b1;
        tick();
        check_val("wr_en_t1", {mem_en, mem_we}, 2'b11);
        check_val("wr_gnt_t1", {gnt_d, gnt_f, gnt_g}, 3'b010);
        check_val("wr_addr_t1", mem_addr, 16'h0003);
        check_val("wr_wdata_t1", mem_wdata, 32'h12345678);
        tick();
        check_val("wr_we_t2", mem_we, 0);
        tick();
        check_val("wr_done_t3", done_f, 1);
        check_val("wr_rdata_kept", rdata, 32'hDEADBEEF);
        check_val("wr_mem_addr", wr_addr, 16'h0003);
        check_val("wr_mem_data", wr_data, 32'h12345678);
        req_f = 1'b0; we_f = 1'b0;
        tick();

        // simultaneous requests: d, f, g in order, 4 cycles apart
        addr_d = 16'h0010; addr_f = 16'h0020; addr_g = 16'h0030;
        req_d = 1'b1; req_f = 1'b1; req_g = 1'b1;
        run_reqs(12, 1'b0, fd, ff, fg, lg, cd, cf, bad);
        check_val("all_done_d", fd, 3);
        check_val("all_done_f", ff, 7);
        check_val("all_done_g", fg, 11);
        check_val("all_onehot", bad, 0);
        check_val("all_rdata_g", rdata, 32'hA5A50030);
        check_val("all_idle", busy, 0);

        // starvation with STARVE_MAX=2, all requesters held high
        req_d = 1'b1; req_f = 1'b1; req_g = 1'b1;
        run_reqs(23, 1'b1, fd, ff, fg, lg, cd, cf, bad);
        check_val("stv_first_g", fg, 11);
        check_val("stv_second_g", lg, 23);
        check_val("stv_cnt_d", cd, 4);
        check_val("stv_cnt_f", cf, 0);
        check_val("stv_onehot", bad, 0);
        req_d = 1'b0; req_f = 1'b0; req_g = 1'b0;
        tick();
        check_val("stv_idle", busy, 0);

        // hold: only g eligible, then d after release
        hold = 1'b1;
        req_d = 1'b1; req_f = 1'b1; req_g = 1'b1;
        run_reqs(12, 1'b0, fd, ff, fg, lg, cd, cf, bad);
        check_val("hold_done_g", fg, 3);
        check_val("hold_done_d", fd, 7);
        check_val("hold_done_f", ff, 11);
        check_val("hold_onehot", bad, 0);
        tick();

        // reset during WAIT of a d read
        addr_d = 16'h0010; req_d = 1'b1;
        tick();
        tick();
        check_val("abort_busy_wait", {busy, gnt_d}, 2'b11);
        rst = 1'b1;
        #1;
        check_val("abort_async", {gnt_d, mem_en, busy}, 0);
        check_val("abort_rdata", rdata, 0);
        req_d = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done_d) n_done++;
        end
        check_val("abort_no_done", n_done, 0);

        // new read after reset; both latencies observed together
        addr_d = 16'h0020; req_d = 1'b1;
        d1_first = -1; d2_first = -1; d2_en = -1; d2_rd_seen = '0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (done_d && d1_first < 0) d1_first = c;
            if (d2_mem_en && d2_en < 0) d2_en = c;
            if (d2_done_d && d2_first < 0) begin
                d2_first   = c;
                d2_rd_seen = d2_rdata;
                req_d      = 1'b0;
            end
        end
        check_val("post_rst_done", d1_first, 3);
        check_val("post_rst_rdata", rdata, 32'hA5A50020);
        check_val("lat4_en", d2_en, 1);
        check_val("lat4_done", d2_first, 6);
        check_val("lat4_rdata", d2_rd_seen, 32'hA5A50020);
        check_val("final_idle", {busy, d2_busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
